// File: rtl/ram_mp_pkg.sv
// Shared constants and state encoding for the multi-port byte-banked RAM.
package ram_mp_pkg;

  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned XLEN_WIDTH = 32;

  typedef enum logic [0:0] {
    RAM_ST_CLEAR = 1'b0,
    RAM_ST_RUN   = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_mp_if.sv
// Read/write bus of ram_mp: NUM_RD read ports plus one strobed write port.
interface ram_mp_if
  import ram_mp_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_WIDTH,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_RD     = 2
) ();

  localparam int unsigned NB = XLEN / BYTE_WIDTH;

  logic                         ready;
  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*XLEN-1:0]       rd_data;
  logic [NUM_RD-1:0]            rd_valid;
  logic                         wr_en;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [NB-1:0]                wr_strb;
  logic [XLEN-1:0]              wr_data;

  modport master (
    input  ready, rd_data, rd_valid,
    output rd_en, rd_addr, wr_en, wr_addr, wr_strb, wr_data
  );

  modport slave (
    output ready, rd_data, rd_valid,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_strb, wr_data
  );

endinterface

// File: rtl/ram_byte_lane.sv
// One byte-wide storage lane: 2**ROW_W rows, NUM_RD registered read ports, one write port.
module ram_byte_lane
  import ram_mp_pkg::*;
#(
  parameter int unsigned ROW_W     = 14,
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned WR_BYPASS = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_RD-1:0]                   rd_en,
  input  logic [NUM_RD-1:0][ROW_W-1:0]        rd_row,
  output logic [NUM_RD-1:0][BYTE_WIDTH-1:0]   rd_byte,
  input  logic                                wr_en,
  input  logic [ROW_W-1:0]                    wr_row,
  input  logic [BYTE_WIDTH-1:0]               wr_byte
);

  localparam int unsigned DEPTH = 2 ** ROW_W;

  logic [BYTE_WIDTH-1:0]             mem_q [DEPTH];
  logic [NUM_RD-1:0][BYTE_WIDTH-1:0] rd_q;
  logic [NUM_RD-1:0][BYTE_WIDTH-1:0] rd_d;

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_row] <= wr_byte;
    end
  end

  // Per-port read select, optionally forwarding a same-row write.
  always_comb begin
    rd_d = rd_q;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rd_en[p]) begin
        if ((WR_BYPASS != 0) && wr_en && (wr_row == rd_row[p])) begin
          rd_d[p] = wr_byte;
        end else begin
          rd_d[p] = mem_q[rd_row[p]];
        end
      end
    end
  end

  // Read data registers: cleared on reset, held when a port is idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_byte = rd_q;

endmodule

// File: rtl/ram_mp.sv
// Byte-addressed multi-read-port RAM with unaligned access, strobes and post-reset clear.
module ram_mp
  import ram_mp_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_WIDTH,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned WR_BYPASS  = 0,
  parameter int unsigned CLEAR_EN   = 1
) (
  input  logic     clk,
  input  logic     rst,
  ram_mp_if.slave  bus
);

  localparam int unsigned NB    = XLEN / BYTE_WIDTH;
  localparam int unsigned LW    = $clog2(NB);
  localparam int unsigned ROW_W = ADDR_WIDTH - LW;
  localparam int unsigned DEPTH = 2 ** ROW_W;

  ram_state_e                   state_q, state_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic                         ready_q, ready_d;
  logic [NUM_RD-1:0]            rd_valid_q, rd_valid_d;
  logic [NUM_RD-1:0][LW-1:0]    off_q, off_d;

  logic [NB-1:0]                                 ln_wr_en;
  logic [NB-1:0][ROW_W-1:0]                      ln_wr_row;
  logic [NB-1:0][BYTE_WIDTH-1:0]                 ln_wr_byte;
  logic [NB-1:0][NUM_RD-1:0]                     ln_rd_en;
  logic [NB-1:0][NUM_RD-1:0][ROW_W-1:0]          ln_rd_row;
  logic [NB-1:0][NUM_RD-1:0][BYTE_WIDTH-1:0]     ln_rd_byte;

  // Clear sequencer, ready flag, read accept and lane-offset capture.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    ready_d    = ready_q;
    rd_valid_d = '0;
    off_d      = off_q;
    case (state_q)
      RAM_ST_CLEAR: begin
        ready_d = 1'b0;
        row_d   = row_q + ROW_W'(1);
        if (row_q == ROW_W'(DEPTH - 1)) begin
          state_d = RAM_ST_RUN;
          ready_d = 1'b1;
          row_d   = '0;
        end
      end
      default: begin
        ready_d = 1'b1;
      end
    endcase
    for (int p = 0; p < NUM_RD; p++) begin
      if (ready_q && bus.rd_en[p]) begin
        rd_valid_d[p] = 1'b1;
        off_d[p]      = bus.rd_addr[p*ADDR_WIDTH +: LW];
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= (CLEAR_EN != 0) ? RAM_ST_CLEAR : RAM_ST_RUN;
      row_q      <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= '0;
      off_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      off_q      <= off_d;
    end
  end

  // Address rotation: each lane gets the row holding the byte of the word that falls in it.
  always_comb begin : lane_map
    logic [LW-1:0]         k;
    logic [ADDR_WIDTH-1:0] a;
    k          = '0;
    a          = '0;
    ln_wr_en   = '0;
    ln_wr_row  = '0;
    ln_wr_byte = '0;
    ln_rd_en   = '0;
    ln_rd_row  = '0;
    for (int l = 0; l < NB; l++) begin
      k = LW'(LW'(l) - bus.wr_addr[LW-1:0]);
      a = bus.wr_addr + ADDR_WIDTH'(k);
      if (state_q == RAM_ST_CLEAR) begin
        ln_wr_en[l]  = rst;
        ln_wr_row[l] = row_q;
      end else begin
        ln_wr_en[l]   = rst & ready_q & bus.wr_en & bus.wr_strb[k];
        ln_wr_row[l]  = a[ADDR_WIDTH-1:LW];
        ln_wr_byte[l] = bus.wr_data[BYTE_WIDTH*k +: BYTE_WIDTH];
      end
      for (int p = 0; p < NUM_RD; p++) begin
        k = LW'(LW'(l) - bus.rd_addr[p*ADDR_WIDTH +: LW]);
        a = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] + ADDR_WIDTH'(k);
        ln_rd_en[l][p]  = ready_q & bus.rd_en[p];
        ln_rd_row[l][p] = a[ADDR_WIDTH-1:LW];
      end
    end
  end

  // Byte lanes.
  for (genvar l = 0; l < NB; l++) begin : g_lane
    ram_byte_lane #(
      .ROW_W     (ROW_W),
      .NUM_RD    (NUM_RD),
      .WR_BYPASS (WR_BYPASS)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (ln_rd_en[l]),
      .rd_row  (ln_rd_row[l]),
      .rd_byte (ln_rd_byte[l]),
      .wr_en   (ln_wr_en[l]),
      .wr_row  (ln_wr_row[l]),
      .wr_byte (ln_wr_byte[l])
    );
  end

  // Reassemble little-endian words from the registered lane bytes using the captured offset.
  always_comb begin : rd_reorder
    logic [LW-1:0] l;
    l           = '0;
    bus.rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int k = 0; k < NB; k++) begin
        l = off_q[p] + LW'(k);
        bus.rd_data[p*XLEN + BYTE_WIDTH*k +: BYTE_WIDTH] = ln_rd_byte[l][p];
      end
    end
  end

  assign bus.ready    = ready_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_mp.sv
// Bench for ram_mp: two instances (old-data and forwarding read-during-write) driven identically.
module tb_ram_mp;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_en;
  logic [5:0]  rd_addr [2];
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;

  ram_mp_if #(.XLEN(32), .ADDR_WIDTH(AW), .NUM_RD(2)) if0 ();
  ram_mp_if #(.XLEN(32), .ADDR_WIDTH(AW), .NUM_RD(2)) if1 ();

  ram_mp #(.XLEN(32), .ADDR_WIDTH(AW), .NUM_RD(2), .WR_BYPASS(0), .CLEAR_EN(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  ram_mp #(.XLEN(32), .ADDR_WIDTH(AW), .NUM_RD(2), .WR_BYPASS(1), .CLEAR_EN(1))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if0.rd_en   = rd_en;
  assign if0.rd_addr = {rd_addr[1], rd_addr[0]};
  assign if0.wr_en   = wr_en;
  assign if0.wr_addr = wr_addr;
  assign if0.wr_strb = wr_strb;
  assign if0.wr_data = wr_data;
  assign if1.rd_en   = rd_en;
  assign if1.rd_addr = {rd_addr[1], rd_addr[0]};
  assign if1.wr_en   = wr_en;
  assign if1.wr_addr = wr_addr;
  assign if1.wr_strb = wr_strb;
  assign if1.wr_data = wr_data;

  logic [31:0] got_data  [2][2];
  logic [1:0]  got_valid [2];
  logic        got_ready [2];

  assign got_data[0][0] = if0.rd_data[31:0];
  assign got_data[0][1] = if0.rd_data[63:32];
  assign got_data[1][0] = if1.rd_data[31:0];
  assign got_data[1][1] = if1.rd_data[63:32];
  assign got_valid[0]   = if0.rd_valid;
  assign got_valid[1]   = if1.rd_valid;
  assign got_ready[0]   = if0.ready;
  assign got_ready[1]   = if1.ready;

  // Reference model: flat byte array plus ready/clear bookkeeping.
  logic [7:0]  m_mem [64];
  bit          m_ready;
  int          m_clr;
  logic [31:0] exp_data [2][2];
  logic [1:0]  exp_valid;
  int          total;
  int          bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict the outcome of the next edge from current inputs, then advance one cycle.
  task automatic cycle();
    logic [5:0]  a;
    int          k2;
    logic [31:0] o;
    logic [31:0] n;
    if (!rst) begin
      m_ready   = 1'b0;
      m_clr     = 0;
      exp_valid = '0;
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) exp_data[d][p] = '0;
    end else if (!m_ready) begin
      exp_valid = '0;
      m_clr++;
      if (m_clr == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rd_en[p]) begin
          for (int k = 0; k < 4; k++) begin
            a  = 6'(rd_addr[p] + 6'(k));
            k2 = int'(6'(a - wr_addr));
            o[8*k +: 8] = m_mem[a];
            n[8*k +: 8] = (wr_en && k2 < 4 && wr_strb[k2]) ? wr_data[8*k2 +: 8] : m_mem[a];
          end
          exp_data[0][p] = o;
          exp_data[1][p] = n;
          exp_valid[p]   = 1'b1;
        end else begin
          exp_valid[p] = 1'b0;
        end
      end
      if (wr_en)
        for (int k = 0; k < 4; k++)
          if (wr_strb[k]) m_mem[6'(wr_addr + 6'(k))] = wr_data[8*k +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (3) cycle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (got_ready[d] !== 1'b0 || got_valid[d] !== 2'b00) begin
        bad++;
        $display("FAIL reset_ctl dut%0d: ready=%b valid=%b want 0/00", d, got_ready[d], got_valid[d]);
      end
      for (int p = 0; p < 2; p++) begin
        total++;
        if (got_data[d][p] !== 32'h0) begin
          bad++;
          $display("FAIL reset_data dut%0d port%0d: got %h want 00000000", d, p, got_data[d][p]);
        end
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= int'(DEPTH); i++) begin
      cycle();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (got_ready[d] !== ((i == int'(DEPTH)) ? 1'b1 : 1'b0)) begin
          bad++;
          $display("FAIL clear_ready dut%0d cycle%0d: got %b want %b", d, i, got_ready[d], i == int'(DEPTH));
        end
      end
    end
    rd_en = 2'b11;
    rd_addr[0] = 6'h00;
    rd_addr[1] = 6'h3C;
    cycle();
    idle();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        total++;
        if (got_data[d][p] !== 32'h0 || got_valid[d][p] !== 1'b1) begin
          bad++;
          $display("FAIL clear_read dut%0d port%0d: got %h/%b want 00000000/1", d, p, got_data[d][p], got_valid[d][p]);
        end
      end
  endtask

  task automatic test_aligned();
    wr_en = 1'b1; wr_addr = 6'h10; wr_strb = 4'hF; wr_data = 32'hDEADBEEF;
    cycle();
    idle();
    rd_en = 2'b01; rd_addr[0] = 6'h10;
    cycle();
    idle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (got_data[d][0] !== 32'hDEADBEEF || got_valid[d] !== 2'b01) begin
        bad++;
        $display("FAIL aligned dut%0d: got %h/%b want deadbeef/01", d, got_data[d][0], got_valid[d]);
      end
    end
    cycle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (got_valid[d] !== 2'b00 || got_data[d][0] !== exp_data[d][0]) begin
        bad++;
        $display("FAIL idle_hold dut%0d: got %h/%b want %h/00", d, got_data[d][0], got_valid[d], exp_data[d][0]);
      end
    end
  endtask

  task automatic test_strobe_unaligned();
    wr_en = 1'b1; wr_addr = 6'h11; wr_strb = 4'b0001; wr_data = 32'h000000AA;
    cycle();
    idle();
    rd_en = 2'b11; rd_addr[0] = 6'h10; rd_addr[1] = 6'h12;
    cycle();
    idle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (got_data[d][0] !== 32'hDEADAAEF) begin
        bad++;
        $display("FAIL strobe dut%0d: got %h want deadaaef", d, got_data[d][0]);
      end
      total++;
      if (got_data[d][1] !== 32'h0000DEAD) begin
        bad++;
        $display("FAIL unaligned dut%0d: got %h want 0000dead", d, got_data[d][1]);
      end
    end
  endtask

  task automatic test_wrap();
    wr_en = 1'b1; wr_addr = 6'h3E; wr_strb = 4'hF; wr_data = 32'h44332211;
    cycle();
    idle();
    rd_en = 2'b11; rd_addr[0] = 6'h3E; rd_addr[1] = 6'h00;
    cycle();
    idle();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (got_data[d][0] !== 32'h44332211) begin
        bad++;
        $display("FAIL wrap dut%0d: got %h want 44332211", d, got_data[d][0]);
      end
      total++;
      if (got_data[d][1] !== 32'h00004433) begin
        bad++;
        $display("FAIL wrap_low dut%0d: got %h want 00004433", d, got_data[d][1]);
      end
    end
  endtask

  task automatic test_rdw();
    rd_en = 2'b11; rd_addr[0] = 6'h20; rd_addr[1] = 6'h20;
    wr_en = 1'b1; wr_addr = 6'h20; wr_strb = 4'hF; wr_data = 32'h12345678;
    cycle();
    idle();
    for (int p = 0; p < 2; p++) begin
      total++;
      if (got_data[0][p] !== 32'h00000000) begin
        bad++;
        $display("FAIL rdw_old port%0d: got %h want 00000000", p, got_data[0][p]);
      end
      total++;
      if (got_data[1][p] !== 32'h12345678) begin
        bad++;
        $display("FAIL rdw_new port%0d: got %h want 12345678", p, got_data[1][p]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rd_en      = 2'($urandom);
      rd_addr[0] = 6'($urandom_range(0, 11)) + 6'd58;
      rd_addr[1] = ($urandom_range(0, 1) == 0) ? 6'($urandom) : 6'($urandom_range(0, 11)) + 6'd58;
      wr_en      = 1'($urandom);
      wr_addr    = 6'($urandom_range(0, 11)) + 6'd58;
      wr_strb    = 4'($urandom);
      wr_data    = $urandom;
      cycle();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (got_valid[d] !== exp_valid) begin
          bad++;
          $display("FAIL rand_valid dut%0d it%0d: got %b want %b", d, i, got_valid[d], exp_valid);
        end
        for (int p = 0; p < 2; p++) begin
          total++;
          if (got_data[d][p] !== exp_data[d][p]) begin
            bad++;
            $display("FAIL rand_data dut%0d port%0d it%0d: got %h want %h", d, p, i, got_data[d][p], exp_data[d][p]);
          end
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    repeat (5) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 1; i <= int'(DEPTH); i++) begin
      rd_en      = 2'b11;
      rd_addr[0] = 6'($urandom);
      rd_addr[1] = 6'($urandom);
      wr_en      = 1'b1;
      wr_addr    = 6'($urandom);
      wr_strb    = 4'hF;
      wr_data    = $urandom;
      cycle();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (got_ready[d] !== ((i == int'(DEPTH)) ? 1'b1 : 1'b0) || got_valid[d] !== 2'b00) begin
          bad++;
          $display("FAIL midreset_ctl dut%0d cycle%0d: ready=%b valid=%b want %b/00", d, i, got_ready[d], got_valid[d], i == int'(DEPTH));
        end
        for (int p = 0; p < 2; p++) begin
          total++;
          if (got_data[d][p] !== exp_data[d][p]) begin
            bad++;
            $display("FAIL midreset_hold dut%0d port%0d: got %h want %h", d, p, got_data[d][p], exp_data[d][p]);
          end
        end
      end
    end
    idle();
    for (int i = 0; i < 32; i++) begin
      rd_en = 2'b11;
      rd_addr[0] = 6'(2 * i);
      rd_addr[1] = 6'(2 * i + 1);
      cycle();
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          total++;
          if (got_data[d][p] !== exp_data[d][p] || got_valid[d][p] !== 1'b1) begin
            bad++;
            $display("FAIL midreset_read dut%0d port%0d i%0d: got %h want %h", d, p, i, got_data[d][p], exp_data[d][p]);
          end
        end
    end
    idle();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    m_ready    = 1'b0;
    m_clr      = 0;
    rst        = 1'b0;
    rd_en      = '0;
    rd_addr[0] = '0;
    rd_addr[1] = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_strb    = '0;
    wr_data    = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) exp_data[d][p] = '0;
    exp_valid = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_aligned();
    test_strobe_unaligned();
    test_wrap();
    test_rdw();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
